// File: rtl/cache_sa.sv
// cache_sa: N-way set-associative, write-back, write-allocate cache with true-LRU replacement.
// Define CACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counters.
module cache_sa #(
  parameter int WAYS        = 2,
  parameter int SETS        = 4,
  parameter int BLOCK_WORDS = 4,
  parameter int ADDR_W      = 30
) (
  input  logic                                   clk,
  input  logic                                   proc_reset,
  input  logic                                   proc_read,
  input  logic                                   proc_write,
  input  logic [ADDR_W-1:0]                      proc_addr,
  input  logic [31:0]                            proc_wdata,
  output logic                                   proc_stall,
  output logic [31:0]                            proc_rdata,
  output logic                                   mem_read,
  output logic                                   mem_write,
  output logic [ADDR_W-$clog2(BLOCK_WORDS)-1:0]  mem_addr,
  output logic [32*BLOCK_WORDS-1:0]              mem_wdata,
  input  logic [32*BLOCK_WORDS-1:0]              mem_rdata,
`ifdef CACHE_PERF_CNT_EN
  output logic [31:0]                            hit_cnt,
  output logic [31:0]                            miss_cnt,
`endif
  input  logic                                   mem_ready
);
  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = 32 * BLOCK_WORDS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t           state_q, next_state;
  logic             valid_q [SETS][WAYS];
  logic             dirty_q [SETS][WAYS];
  logic [WAY_W-1:0] rank_q  [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [BLK_W-1:0] data_q  [SETS][WAYS];
  logic [WAY_W-1:0] victim_q;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;
  logic             req, do_write;

  assign req_tag  = proc_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = proc_addr[OFF_W +: IDX_W];
  assign req_off  = proc_addr[OFF_W-1:0];
  assign req      = proc_read | proc_write;
  assign do_write = proc_write & ~proc_read;  // read wins when both are raised

  function automatic logic [31:0] get_word(input logic [BLK_W-1:0] blk, input logic [OFF_W-1:0] off);
    return blk[32*off +: 32];
  endfunction

  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk, input logic [OFF_W-1:0] off,
                                                 input logic [31:0] word);
    logic [BLK_W-1:0] r;
    r = blk;
    r[32*off +: 32] = word;
    return r;
  endfunction

  // Tag lookup and victim choice for the addressed set.
  logic             hit, inv_found;
  logic [WAY_W-1:0] hit_way, inv_way, lru_way, victim_sel;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[req_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (rank_q[req_idx][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
    end
    victim_sel = inv_found ? inv_way : lru_way;
  end

  logic             miss_start, upd_en, upd_dirty, data_we;
  logic [WAY_W-1:0] upd_way;
  logic [BLK_W-1:0] upd_blk;

  always_comb begin
    next_state = state_q;
    proc_stall = 1'b0;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    miss_start = 1'b0;
    upd_en     = 1'b0;
    upd_dirty  = 1'b0;
    data_we    = 1'b0;
    upd_way    = hit_way;
    upd_blk    = '0;
    case (state_q)
      IDLE: begin
        if (req && hit) begin
          upd_en    = 1'b1;
          upd_dirty = dirty_q[req_idx][hit_way] | do_write;
          data_we   = do_write;
          upd_blk   = put_word(data_q[req_idx][hit_way], req_off, proc_wdata);
          if (proc_read) proc_rdata = get_word(data_q[req_idx][hit_way], req_off);
        end else if (req) begin
          proc_stall = 1'b1;
          miss_start = 1'b1;
          next_state = (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[req_idx][victim_q], req_idx};
        mem_wdata  = data_q[req_idx][victim_q];
        if (mem_ready) next_state = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = ~mem_ready;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[ADDR_W-1:OFF_W];
        if (mem_ready) begin
          upd_en     = 1'b1;
          upd_way    = victim_q;
          upd_dirty  = do_write;
          data_we    = 1'b1;
          upd_blk    = do_write ? put_word(mem_rdata, req_off, proc_wdata) : mem_rdata;
          next_state = IDLE;
          if (proc_read) proc_rdata = get_word(mem_rdata, req_off);
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q  <= IDLE;
      victim_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          rank_q[s][w]  <= WAY_W'(w);
        end
      end
    end else begin
      state_q <= next_state;
      if (miss_start) victim_q <= victim_sel;
      if (upd_en) begin
        valid_q[req_idx][upd_way] <= 1'b1;
        dirty_q[req_idx][upd_way] <= upd_dirty;
        // Touched way becomes MRU; only ways that were more recent age by one.
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == upd_way)
            rank_q[req_idx][w] <= '0;
          else if (rank_q[req_idx][w] < rank_q[req_idx][upd_way])
            rank_q[req_idx][w] <= rank_q[req_idx][w] + 1'b1;
        end
      end
    end
  end

  // NOTE: tag and data arrays have no reset; the valid bits alone decide whether they are used.
  always_ff @(posedge clk) begin
    if (!proc_reset && upd_en) begin
      tag_q[req_idx][upd_way] <= req_tag;
      if (data_we) data_q[req_idx][upd_way] <= upd_blk;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (upd_en && state_q == IDLE) hit_cnt <= hit_cnt + 32'd1;
      if (miss_start) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_sa.sv
// tb_cache_sa: scoreboard bench for cache_sa (2 ways, 4 sets, 4-word blocks) against a flat-memory + LRU-list model.
module tb_cache_sa;
  localparam int WAYS = 2;
  localparam int SETS = 4;

  logic         clk = 1'b0;
  logic         proc_reset, proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read, mem_write, mem_ready;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  cache_sa #(.WAYS(2), .SETS(4), .BLOCK_WORDS(4), .ADDR_W(30)) dut (
    .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef CACHE_PERF_CNT_EN
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
    .mem_ready(mem_ready)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no completion within cycle bound", name);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  // Backing memory (what the DUT talks to) and the reference flat memory (what the processor should see).
  logic [31:0] bmem    [int];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] init_word(input int a);
    return 32'(a) * 32'h9E37_79B1 + 32'h1234_5677;
  endfunction
  function automatic logic [31:0] bm_rd(input int a);
    return bmem.exists(a) ? bmem[a] : init_word(a);
  endfunction
  function automatic logic [31:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  typedef struct packed {
    bit           is_read;
    logic [31:0]  rdata;
    bit           miss;
    bit           wb;
    logic [27:0]  wb_addr;
    logic [127:0] wb_data;
    logic [27:0]  fill_addr;
  } exp_t;

  exp_t sb_q [$];
  int   lru [SETS][$];     // block addresses per set, most recent first
  bit   dirty_blk [int];
  int   m_hits = 0;
  int   m_misses = 0;

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) lru[s].delete();
    dirty_blk.delete();
    ref_mem  = bmem;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model(input bit rd, input bit wr, input logic [29:0] addr, input logic [31:0] wd,
                       output exp_t e);
    int a, blk, set, pos, v;
    a   = int'(addr);
    blk = a >> 2;
    set = blk % SETS;
    e   = '0;
    e.is_read = rd;
    pos = -1;
    for (int j = 0; j < lru[set].size(); j++) if (lru[set][j] == blk) pos = j;
    if (pos >= 0) begin
      lru[set].delete(pos);
      m_hits++;
    end else begin
      e.miss      = 1'b1;
      e.fill_addr = 28'(blk);
      m_misses++;
      if (lru[set].size() == WAYS) begin
        v = lru[set].pop_back();
        if (dirty_blk.exists(v)) begin
          e.wb      = 1'b1;
          e.wb_addr = 28'(v);
          for (int i = 0; i < 4; i++) e.wb_data[32*i +: 32] = ref_rd(v * 4 + i);
          dirty_blk.delete(v);
        end
      end
    end
    lru[set].push_front(blk);
    if (wr && !rd) begin
      ref_mem[a]     = wd;
      dirty_blk[blk] = 1'b1;
    end
    if (rd) e.rdata = ref_rd(a);
  endtask

  // Observation state shared by responder (writes at posedge+2) and monitor (reads at negedge).
  int           stall_cnt = 0, mem_cnt = 0, cd = 0;
  bit           wb_seen = 0, fill_seen = 0, mem_unstable = 0, both_hi = 0;
  bit           hold = 0, force_spur = 0, was_rdy;
  logic [27:0]  wb_addr, fill_addr;
  logic [127:0] wb_data;

  task automatic clear_obs();
    stall_cnt = 0; mem_cnt = 0; wb_seen = 0; fill_seen = 0; mem_unstable = 0;
  endtask

  // Memory responder: random latency, plus stray mem_ready pulses while the bus is idle.
  always @(posedge clk) begin
    #2;
    was_rdy   = mem_ready;
    mem_ready = 1'b0;
    if (mem_read && mem_write) both_hi = 1'b1;
    if (mem_read || mem_write) begin
      mem_cnt++;
      if (mem_write) begin
        if (!wb_seen) begin
          wb_seen = 1'b1; wb_addr = mem_addr; wb_data = mem_wdata;
        end else if (mem_addr !== wb_addr || mem_wdata !== wb_data) mem_unstable = 1'b1;
      end
      if (mem_read) begin
        if (!fill_seen) begin
          fill_seen = 1'b1; fill_addr = mem_addr;
        end else if (mem_addr !== fill_addr) mem_unstable = 1'b1;
      end
      if (!was_rdy && !hold) begin
        if (cd == 0) begin
          for (int i = 0; i < 4; i++) begin
            if (mem_write) bmem[int'(mem_addr) * 4 + i] = mem_wdata[32*i +: 32];
            else mem_rdata[32*i +: 32] = bm_rd(int'(mem_addr) * 4 + i);
          end
          mem_ready = 1'b1;
        end else cd--;
      end
    end else if (!was_rdy && (force_spur || (!hold && $urandom_range(0, 7) == 0))) begin
      force_spur = 1'b0;
      mem_rdata  = {$urandom, $urandom, $urandom, $urandom};
      mem_ready  = 1'b1;
    end
    if (was_rdy) cd = $urandom_range(0, 3);
  end

  // Monitor: one scoreboard pop per completed request.
  always @(negedge clk) begin
    exp_t e;
    if (!proc_reset && (proc_read || proc_write)) begin
      if (proc_stall) stall_cnt++;
      else if (sb_q.size() == 0) check("unexpected_completion", 1, 0);
      else begin
        e = sb_q.pop_front();
        if (e.is_read) check("rdata", proc_rdata, e.rdata);
        check("miss", stall_cnt != 0, e.miss);
        check("stall_vs_mem_cycles", stall_cnt, mem_cnt);
        check("writeback_seen", wb_seen, e.wb);
        if (e.wb) begin
          check("wb_addr", wb_addr, e.wb_addr);
          check("wb_data", wb_data, e.wb_data);
        end
        if (e.miss) check("fill_addr", fill_addr, e.fill_addr);
        check("mem_held_stable", mem_unstable, 0);
        clear_obs();
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr, input logic [29:0] addr, input logic [31:0] wd);
    exp_t e;
    model(rd, wr, addr, wd, e);
    sb_q.push_back(e);
    @(posedge clk); #1;
    proc_read = rd; proc_write = wr; proc_addr = addr; proc_wdata = wd;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (!proc_stall) break;
      if (c > 60) bail("request_timeout");
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    proc_read = 1'b0; proc_write = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;
    @(negedge clk); #1;
    model_clear();
    clear_obs();
  endtask

  task automatic reset_mid_alloc(input logic [29:0] addr);
    hold = 1'b1;
    @(posedge clk); #1;
    proc_read = 1'b1; proc_write = 1'b0; proc_addr = addr;
    for (int c = 0; ; c++) begin
      @(negedge clk);
      if (mem_read) break;
      if (c > 10) bail("abort_wait_mem_read");
    end
    check("abort_mem_read_before", mem_read, 1);
    @(posedge clk); #1;
    proc_reset = 1'b1; proc_read = 1'b0;
    @(posedge clk); #1;
    proc_reset = 1'b0;
    @(negedge clk);
    check("abort_mem_read_after", mem_read, 0);
    check("abort_mem_write_after", mem_write, 0);
    #1 force_spur = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_late_ready_ignored", {mem_read, mem_write, proc_stall}, 3'b000);
    #1;
    hold = 1'b0;
    model_clear();
    clear_obs();
    do_req(1'b1, 1'b0, addr, 32'h0);
  endtask

  initial begin : main
    logic [25:0] tags [5];
    logic [29:0] a;
    int k;
    tags = '{26'h0, 26'h1, 26'h2, 26'h5, 26'h3FF_FFFF};
    proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
    proc_addr = '0; proc_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1 proc_reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_proc_rdata", proc_rdata, 0);
    check("rst_proc_stall", proc_stall, 0);

    // Cold read miss then hits, including back-to-back hits
    do_req(1, 0, 30'h12, 0);
    do_req(1, 0, 30'h13, 0);
    do_req(1, 0, 30'h10, 0);
    do_req(1, 0, 30'h11, 0);
    go_idle();
`ifdef CACHE_PERF_CNT_EN
    @(negedge clk);
    check("miss_cnt_scn1", miss_cnt, 32'(m_misses));
    check("hit_cnt_scn1", hit_cnt, 32'(m_hits));
`endif

    // Two-way fill, then LRU eviction of the tag-5 block
    apply_reset();
    do_req(1, 0, 30'h10, 0);
    do_req(1, 0, 30'h50, 0);
    do_req(1, 0, 30'h10, 0);
    do_req(1, 0, 30'h50, 0);
    do_req(1, 0, 30'h10, 0);
    do_req(1, 0, 30'h90, 0);
    do_req(1, 0, 30'h10, 0);
    do_req(1, 0, 30'h50, 0);

    // Dirty write-back, then read+write together behaving as a read
    apply_reset();
    do_req(0, 1, 30'h11, 32'hCAFE_BABE);
    do_req(1, 0, 30'h51, 0);
    do_req(1, 0, 30'h91, 0);
    do_req(1, 1, 30'h92, 32'hDEAD_0001);
    do_req(1, 0, 30'h92, 0);
    go_idle();

    reset_mid_alloc(30'h12);
    go_idle();

    for (int i = 0; i < 400; i++) begin
      a = {tags[$urandom_range(0, 4)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      k = $urandom_range(0, 11);
      if (k < 5) do_req(1, 0, a, 0);
      else if (k < 9) do_req(0, 1, a, $urandom);
      else if (k < 10) do_req(1, 1, a, $urandom);
      else go_idle();
    end
    go_idle();

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    check("mem_rw_exclusive", both_hi, 0);
`ifdef CACHE_PERF_CNT_EN
    check("miss_cnt_final", miss_cnt, 32'(m_misses));
    check("hit_cnt_final", hit_cnt, 32'(m_hits));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
